// File: rtl/felix_crc20_checker.sv
// Receive-side CRC20 checker for the WIB-to-FELIX 32-bit frame stream.
// Data passes through with 1-cycle latency; status pulses and counters run alongside.
module felix_crc20_checker #(
    parameter int MAX_WORDS = 128,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       din,
    input  logic              din_valid,
    input  logic              din_sof,
    input  logic              din_eof,
    input  logic              clr_cnt,
    output logic [31:0]       dout,
    output logic              dout_valid,
    output logic              dout_sof,
    output logic              dout_eof,
    output logic              frame_ok,
    output logic              crc_err,
    output logic              frm_err,
    output logic [19:0]       calc_crc,
    output logic [19:0]       rx_crc,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic [CNT_W-1:0]  crc_err_cnt,
    output logic [CNT_W-1:0]  frm_err_cnt
);
    localparam logic [19:0] CRC_INIT = 20'hFFFFF;
    localparam logic [19:0] CRC_POLY = 20'hC1ACF;
    localparam int          WC_W     = $clog2(MAX_WORDS + 1);

    typedef enum logic {IDLE, INFRAME} state_t;
    typedef struct packed {
        logic [31:0] data;
        logic        sof;
        logic        eof;
    } word_t;

    // MSB-first LFSR unrolled over one word; matches the transmit-side generator.
    function automatic logic [19:0] crc_upd(input logic [19:0] c, input logic [31:0] d);
        logic [19:0] r;
        logic        fb;
        r = c;
        for (int i = 31; i >= 0; i--) begin
            fb = r[19] ^ d[i];
            r  = {r[18:0], 1'b0} ^ (fb ? CRC_POLY : 20'h0);
        end
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] cnt_nxt(input logic [CNT_W-1:0] c, input logic clr,
                                                 input logic inc);
        if (clr)                    return '0;
        if (inc && c != {CNT_W{1'b1}}) return c + CNT_W'(1);
        return c;
    endfunction

    state_t           state, state_n;
    logic [19:0]      lfsr, lfsr_n;
    logic [WC_W-1:0]  wcnt, wcnt_n;
    logic [19:0]      calc_n, rx_n;
    logic             ok_n, crce_n, frme_n;
    logic [1:0]       vld_pipe;
    word_t            in_w, out_w;

    assign vld_pipe[0] = din_valid;
    assign in_w        = '{data: din, sof: din_sof, eof: din_eof};
    assign dout        = out_w.data;
    assign dout_sof    = out_w.sof;
    assign dout_eof    = out_w.eof;
    assign dout_valid  = vld_pipe[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe[1] <= 1'b0;
            out_w       <= '0;
        end else begin
            vld_pipe[1] <= vld_pipe[0];
            out_w       <= in_w;
        end
    end

    always_comb begin
        state_n = state;
        lfsr_n  = lfsr;
        wcnt_n  = wcnt;
        calc_n  = calc_crc;
        rx_n    = rx_crc;
        ok_n    = 1'b0;
        crce_n  = 1'b0;
        frme_n  = 1'b0;
        if (din_valid) begin
            if (din_sof) begin
                // A SOF always (re)starts; SOF+EOF is a zero-payload frame and counts once.
                frme_n = (state == INFRAME) || din_eof;
                if (din_eof) begin
                    state_n = IDLE;
                    lfsr_n  = CRC_INIT;
                    wcnt_n  = '0;
                end else begin
                    state_n = INFRAME;
                    lfsr_n  = crc_upd(CRC_INIT, din);
                    wcnt_n  = WC_W'(1);
                end
            end else if (state == INFRAME) begin
                if (din_eof) begin
                    calc_n  = lfsr;
                    rx_n    = din[19:0];
                    ok_n    = (din[19:0] == lfsr);
                    crce_n  = (din[19:0] != lfsr);
                    state_n = IDLE;
                    lfsr_n  = CRC_INIT;
                    wcnt_n  = '0;
                end else if (wcnt == WC_W'(MAX_WORDS)) begin
                    frme_n  = 1'b1;
                    state_n = IDLE;
                    lfsr_n  = CRC_INIT;
                    wcnt_n  = '0;
                end else begin
                    lfsr_n = crc_upd(lfsr, din);
                    wcnt_n = wcnt + WC_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            lfsr     <= CRC_INIT;
            wcnt     <= '0;
            calc_crc <= CRC_INIT;
            rx_crc   <= CRC_INIT;
            frame_ok <= 1'b0;
            crc_err  <= 1'b0;
            frm_err  <= 1'b0;
        end else begin
            state    <= state_n;
            lfsr     <= lfsr_n;
            wcnt     <= wcnt_n;
            calc_crc <= calc_n;
            rx_crc   <= rx_n;
            frame_ok <= ok_n;
            crc_err  <= crce_n;
            frm_err  <= frme_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt   <= '0;
            crc_err_cnt <= '0;
            frm_err_cnt <= '0;
        end else begin
            frame_cnt   <= cnt_nxt(frame_cnt, clr_cnt, frame_ok);
            crc_err_cnt <= cnt_nxt(crc_err_cnt, clr_cnt, crc_err);
            frm_err_cnt <= cnt_nxt(frm_err_cnt, clr_cnt, frm_err);
        end
    end
endmodule

// File: tb/tb_felix_crc20_checker.sv
// Scoreboard bench for felix_crc20_checker: a frame-level model predicts each word's
// response, a negedge monitor compares whatever the DUT presents.
module tb_felix_crc20_checker;
    localparam int MAX_WORDS = 128;
    localparam int CNT_W     = 4;
    localparam logic [20:0] POLY_FULL = 21'h1C1ACF;

    logic              clk = 1'b0, rst = 1'b1;
    logic [31:0]       din = '0;
    logic              din_valid = 1'b0, din_sof = 1'b0, din_eof = 1'b0, clr_cnt = 1'b0;
    logic [31:0]       dout;
    logic              dout_valid, dout_sof, dout_eof, frame_ok, crc_err, frm_err;
    logic [19:0]       calc_crc, rx_crc;
    logic [CNT_W-1:0]  frame_cnt, crc_err_cnt, frm_err_cnt;

    felix_crc20_checker #(.MAX_WORDS(MAX_WORDS), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_sof(din_sof),
        .din_eof(din_eof), .clr_cnt(clr_cnt), .dout(dout), .dout_valid(dout_valid),
        .dout_sof(dout_sof), .dout_eof(dout_eof), .frame_ok(frame_ok), .crc_err(crc_err),
        .frm_err(frm_err), .calc_crc(calc_crc), .rx_crc(rx_crc), .frame_cnt(frame_cnt),
        .crc_err_cnt(crc_err_cnt), .frm_err_cnt(frm_err_cnt));

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]      d;
        logic             s, e;
        logic [2:0]       p;     // {frame_ok, crc_err, frm_err}
        logic [19:0]      calc, rx;
        logic [CNT_W-1:0] fc, cc, fe;
    } exp_t;

    exp_t             sb[$];
    int               checks = 0, errors = 0;
    logic             m_open = 1'b0;
    logic [31:0]      mq[$];
    logic [19:0]      m_calc = 20'hFFFFF, m_rx = 20'hFFFFF;
    logic [CNT_W-1:0] m_fc = '0, m_cc = '0, m_fe = '0;
    logic [2:0]       m_pend = '0;

    // CRC as polynomial remainder: state*x^32 + word*x^20 mod P, word by word.
    function automatic logic [19:0] crc_of(input logic [31:0] ws[$]);
        logic [51:0] v;
        logic [19:0] c = 20'hFFFFF;
        foreach (ws[k]) begin
            v = {c, 32'h0} ^ {ws[k], 20'h0};
            for (int i = 51; i >= 20; i--)
                if (v[i]) v = v ^ (52'(POLY_FULL) << (i - 20));
            c = v[19:0];
        end
        return c;
    endfunction

    function automatic logic [CNT_W-1:0] nc(input logic [CNT_W-1:0] c, input logic clr,
                                            input logic inc);
        if (clr) return '0;
        if (inc && c != {CNT_W{1'b1}}) return c + 1'b1;
        return c;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic v, input logic s, input logic e, input logic [31:0] d,
                        input logic clr);
        exp_t       x;
        logic [2:0] p = '0;
        @(posedge clk); #1;
        din_valid = v; din_sof = s; din_eof = e; din = d; clr_cnt = clr;
        m_fc = nc(m_fc, clr, m_pend[2]);
        m_cc = nc(m_cc, clr, m_pend[1]);
        m_fe = nc(m_fe, clr, m_pend[0]);
        if (v) begin
            if (s) begin
                if (m_open || e) p = 3'b001;
                m_open = !e;
                mq.delete();
                if (!e) mq.push_back(d);
            end else if (m_open) begin
                if (e) begin
                    m_calc = crc_of(mq);
                    m_rx   = d[19:0];
                    p      = (m_calc == m_rx) ? 3'b100 : 3'b010;
                    m_open = 1'b0;
                end else if (mq.size() == MAX_WORDS) begin
                    p      = 3'b001;
                    m_open = 1'b0;
                end else mq.push_back(d);
            end
            x = '{d: d, s: s, e: e, p: p, calc: m_calc, rx: m_rx, fc: m_fc, cc: m_cc, fe: m_fe};
            sb.push_back(x);
        end
        m_pend = p;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, $urandom, 1'b0);
    endtask

    task automatic chk_reset();
        check("rst_dout", dout, 32'h0);
        check("rst_qual", {dout_valid, dout_sof, dout_eof}, 32'h0);
        check("rst_pulse", {frame_ok, crc_err, frm_err}, 32'h0);
        check("rst_calc", calc_crc, 32'hFFFFF);
        check("rst_rx", rx_crc, 32'hFFFFF);
        check("rst_cnts", {frame_cnt, crc_err_cnt, frm_err_cnt}, 32'h0);
    endtask

    task automatic do_reset();
        idle(1);
        @(posedge clk); #1;
        rst = 1'b1; din_valid = 1'b0; clr_cnt = 1'b0;
        m_open = 1'b0; mq.delete(); m_calc = 20'hFFFFF; m_rx = 20'hFFFFF;
        m_fc = '0; m_cc = '0; m_fe = '0; m_pend = '0;
        @(negedge clk); chk_reset();
        @(posedge clk); #1; rst = 1'b0;
    endtask

    // Payload from SOF, optional valid gaps, trailer with optional bit flips.
    task automatic send_frame(input int n, input logic [19:0] flip, input bit gaps,
                              input bit rnd_clr);
        logic [31:0] pl[$];
        for (int i = 0; i < n; i++) pl.push_back($urandom);
        foreach (pl[i]) begin
            step(1'b1, i == 0, 1'b0, pl[i], rnd_clr && ($urandom_range(0, 15) == 0));
            if (gaps) step(1'b0, 1'b0, 1'b0, $urandom, 1'b0);
        end
        step(1'b1, 1'b0, 1'b1, {12'($urandom), crc_of(pl) ^ flip}, 1'b0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (dout_valid) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_word: dout=%h with empty scoreboard", dout);
                end else begin
                    exp_t x;
                    x = sb.pop_front();
                    check("dout", dout, x.d);
                    check("dout_qual", {dout_sof, dout_eof}, {x.s, x.e});
                    check("pulses", {frame_ok, crc_err, frm_err}, x.p);
                    check("calc_crc", calc_crc, x.calc);
                    check("rx_crc", rx_crc, x.rx);
                    check("frame_cnt", frame_cnt, x.fc);
                    check("crc_err_cnt", crc_err_cnt, x.cc);
                    check("frm_err_cnt", frm_err_cnt, x.fe);
                end
            end else check("idle_pulses", {frame_ok, crc_err, frm_err}, 32'h0);
        end
    end

    initial begin
        @(negedge clk); chk_reset();
        @(posedge clk); #1; rst = 1'b0;
        // good frame, then same length with trailer bit 0 flipped
        send_frame(4, 20'h0, 1'b0, 1'b0);
        send_frame(4, 20'h00001, 1'b0, 1'b0);
        idle(2);
        // second SOF at word 3 aborts, restarted frame closes good
        begin
            logic [31:0] a, b;
            logic [31:0] q[$];
            a = $urandom; b = $urandom; q = '{a, b};
            step(1'b1, 1'b1, 1'b0, $urandom, 1'b0);
            step(1'b1, 1'b0, 1'b0, $urandom, 1'b0);
            step(1'b1, 1'b1, 1'b0, a, 1'b0);
            step(1'b1, 1'b0, 1'b0, b, 1'b0);
            step(1'b1, 1'b0, 1'b1, {12'h0, crc_of(q)}, 1'b0);
        end
        // zero-payload frame, then overlength frame and an ignored EOF
        step(1'b1, 1'b1, 1'b1, $urandom, 1'b0);
        step(1'b1, 1'b1, 1'b0, $urandom, 1'b0);
        for (int i = 0; i < 129; i++) step(1'b1, 1'b0, 1'b0, $urandom, 1'b0);
        step(1'b1, 1'b0, 1'b1, $urandom, 1'b0);
        // exactly MAX_WORDS payload words still closes normally
        send_frame(MAX_WORDS, 20'h0, 1'b0, 1'b0);
        // gapped frame, clr_cnt coincident with frame_ok
        send_frame(8, 20'h0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, $urandom, 1'b1);
        idle(2);
        // saturate frm_err_cnt
        for (int i = 0; i < 18; i++) step(1'b1, 1'b1, 1'b1, $urandom, 1'b0);
        idle(3);
        // reset mid-frame, then a trailing EOF must be ignored
        step(1'b1, 1'b1, 1'b0, $urandom, 1'b0);
        step(1'b1, 1'b0, 1'b0, $urandom, 1'b0);
        do_reset();
        step(1'b1, 1'b0, 1'b1, $urandom, 1'b0);
        idle(2);
        // random traffic
        for (int f = 0; f < 60; f++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0) step(1'b1, 1'b0, 1'($urandom), $urandom, 1'b0);
            else if (r == 1) step(1'b1, 1'b1, 1'b1, $urandom, 1'b0);
            else if (r == 2) step(1'b1, 1'b1, 1'b0, $urandom, 1'b0);
            else send_frame($urandom_range(1, 12), (r == 3) ? 20'(1 << $urandom_range(0, 19)) : 20'h0,
                            1'($urandom), 1'b1);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(3);
        check("scoreboard_drained", sb.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/felix_crc20_checker.md
Name: felix_crc20_checker

Overview:
- Receive-side integrity checker for the 32-bit WIB-to-FELIX frame stream.
- Recomputes the CRC20 over each frame's payload words and compares it with the CRC carried in the trailer word.
- Flags framing and length errors and maintains saturating status counters.
- Sits after word alignment/deframing and before the event buffer. Data passes through with fixed 1-cycle latency.

Parameters:
- MAX_WORDS, 128: maximum payload words per frame, counting SOF through the last word before EOF.
- CNT_W, 16: width of status counters.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- din  in  32  frame word
- din_valid  in  1  word qualifier
- din_sof  in  1  first word of frame; qualified by din_valid
- din_eof  in  1  trailer word; din[19:0] = transmitted CRC, din[31:20] ignored
- clr_cnt  in  1  synchronous clear of all counters
- dout  out  32  din delayed 1 cycle
- dout_valid / dout_sof / dout_eof  out  1 each  qualifiers delayed 1 cycle
- frame_ok  out  1  pulse: frame closed with CRC match
- crc_err  out  1  pulse: frame closed with CRC mismatch
- frm_err  out  1  pulse: framing or length violation
- calc_crc  out  20  last computed CRC, held
- rx_crc  out  20  last received trailer CRC, held
- frame_cnt  out  CNT_W  good frames
- crc_err_cnt  out  CNT_W  CRC mismatches
- frm_err_cnt  out  CNT_W  framing/length errors

Behaviour:
CRC definition:
- Polynomial x^20+x^19+x^18+x^12+x^11+x^9+x^7+x^6+x^3+x^2+x+1.
- Processes one 32-bit word per cycle, with parallel next-state equations bit-for-bit identical to the transmit-side CRC20 generator.
- Init 0xFFFFF, no reflection, no final XOR.
- Covers every word from SOF up to, but excluding, the EOF word.

Reset (async):
- State IDLE, lfsr = 0xFFFFF, word count 0.
- All outputs 0, except calc_crc = rx_crc = 0xFFFFF.

Cycles where din_valid = 0:
- No state change; pulses are 0.

State IDLE:
- valid & sof & !eof: lfsr <= upd(0xFFFFF, din), wcnt <= 1, go to INFRAME.
- valid & sof & eof: frame has zero payload; frm_err pulse, stay in IDLE.
- valid & !sof: word dropped silently, no flag. A stray EOF is also ignored.

State INFRAME:
- valid & !sof & !eof:
  - If wcnt == MAX_WORDS: frm_err pulse (length), go to IDLE, lfsr <= 0xFFFFF. Words up to the next SOF are then dropped.
  - Else: lfsr <= upd(lfsr, din), wcnt++.
- valid & eof & !sof:
  - Compare din[19:0] with the current lfsr.
  - calc_crc <= lfsr, rx_crc <= din[19:0].
  - Equal: frame_ok pulse. Unequal: crc_err pulse.
  - Go to IDLE, lfsr <= 0xFFFFF.
- valid & sof, with or without eof:
  - The open frame is aborted: frm_err pulse.
  - The same word restarts a new frame exactly as in IDLE.
  - If eof is also set, the new frame is also a zero-payload error; frm_err_cnt increments by 1 only.

Timing:
- Status pulses (frame_ok/crc_err/frm_err) are registered: asserted the cycle after the triggering word and high for exactly 1 cycle.
- At most one of the three is high in any cycle.
- calc_crc/rx_crc update in the same cycle as the pulse.

Counters:
- Increment in the cycle the matching pulse is high.
- Saturate at all-ones; no wrap.
- clr_cnt forces all counters to 0 next cycle. Clear wins over a simultaneous increment.
- clr_cnt does not affect the state machine or the CRC.

Pass-through:
- dout/dout_* are registered copies of din/din_*, independent of checking. Errored frames are not suppressed.

Reset mid-frame:
- The state machine returns to IDLE immediately.
- A following EOF without a new SOF is ignored.

Test Plan:
1. Reset, then a 4-word frame (SOF + 3 words) + EOF whose trailer CRC comes from the golden CRC20 model → frame_ok 1 cycle after EOF; frame_cnt = 1; calc_crc == rx_crc; dout matches din delayed 1 cycle.
2. Same frame with trailer CRC bit 0 flipped → crc_err pulse; crc_err_cnt = 1; rx_crc ^ calc_crc = 0x00001.
3. Frame of 5 words, second SOF at word 3, followed by a valid 2-word frame → frm_err pulse at the second SOF + 1; second frame gives frame_ok; frm_err_cnt = 1, frame_cnt = 1.
4. SOF+EOF in one word, then 130 words without EOF (MAX_WORDS = 128) → frm_err for the single word; second frm_err when the 129th word arrives; the following EOF is ignored; frm_err_cnt = 2.
5. din_valid toggling 1/0 every cycle across a good 8-word frame → frame_ok; CRC identical to the gap-free run. Pulse clr_cnt in the same cycle as frame_ok → frame_cnt = 0.
6. Force frm_err_cnt near saturation (CNT_W = 4 build, 16 errors) → holds at 0xF. Assert rst mid-frame, then send EOF → no pulse; counters 0.
